kernel_cc_write_back_start_ctrl: RTL and testbench

Consumer-side controller for the write_back start-token FIFO in the kernel_cc dataflow region. It pops one start token, runs the ap_start/ap_ready/ap_done/ap_continue handshake with the write_back process, and holds completion until downstream acknowledges it. It also keeps a saturating task counter and a per-task latency measurement for debug/status readout.

---
 rtl/kernel_cc_ctrl_pkg.sv | 20 ++
 rtl/kernel_cc_write_back_start_ctrl_if.sv | 33 +++
 rtl/kernel_cc_sat_counter.sv | 32 +++
 rtl/kernel_cc_write_back_start_ctrl.sv | 113 +++++++++++
 tb/tb_kernel_cc_write_back_start_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_cc_ctrl_pkg.sv
// Shared types and constants for the kernel_cc write_back start-token controller.
// Holds the FSM state encoding and the default counter width.
package kernel_cc_ctrl_pkg;

   localparam int STATE_W           = 2;
   localparam int DEFAULT_CNT_WIDTH = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // START and RUN are the cycles where the write_back process owns the task.
   function automatic logic is_in_flight(input state_t s);
      return (s == ST_START) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/kernel_cc_write_back_start_ctrl_if.sv
// Bundles the start-FIFO, ap_* handshake, completion and status signals of the controller.
// The master modport is the controller's view; slave is the surrounding logic's view.
interface kernel_cc_write_back_start_ctrl_if
   import kernel_cc_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);
   logic                 enable;
   logic                 start_empty_n;
   logic                 start_dout;
   logic                 start_read;
   logic                 proc_start;
   logic                 proc_ready;
   logic                 proc_done;
   logic                 proc_continue;
   logic                 done_out;
   logic                 done_ack;
   logic                 busy;
   logic                 cnt_clear;
   logic [CNT_WIDTH-1:0] task_cnt;
   logic [CNT_WIDTH-1:0] last_lat;

   modport master (
      input  enable, start_empty_n, start_dout, proc_ready, proc_done, done_ack, cnt_clear,
      output start_read, proc_start, proc_continue, done_out, busy, task_cnt, last_lat
   );

   modport slave (
      output enable, start_empty_n, start_dout, proc_ready, proc_done, done_ack, cnt_clear,
      input  start_read, proc_start, proc_continue, done_out, busy, task_cnt, last_lat
   );

endinterface

// File: rtl/kernel_cc_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Priority: clear, then load-one, then increment (which sticks at all-ones).
module kernel_cc_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clear,
   input  logic             i_load1,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load1) begin
         r_count <= ONE;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + ONE;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/kernel_cc_write_back_start_ctrl.sv
// Pops one start token, drives the ap_start/ap_continue handshake with write_back,
// and holds completion until acknowledged; also tracks task count and task latency.
module kernel_cc_write_back_start_ctrl
   import kernel_cc_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH,
   parameter bit BACK_TO_BACK = 1'b1
) (
   input  logic                               clk,
   input  logic                               reset_n,
   kernel_cc_write_back_start_ctrl_if.master  bus
);

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_pop;
   logic                 w_ack;
   logic                 w_capture;
   logic                 w_token_avail;
   logic [CNT_WIDTH-1:0] w_task_cnt;
   logic [CNT_WIDTH-1:0] w_lat_cnt;
   logic [CNT_WIDTH-1:0] r_last_lat;

   // reset_n is folded in so a token waiting during reset is left in the FIFO.
   assign w_token_avail = bus.enable & bus.start_empty_n & reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_ack        = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_token_avail) begin
               w_pop        = 1'b1;
               w_state_next = ST_START;
            end
         end
         ST_START: begin
            if (bus.proc_ready && bus.proc_done) begin
               w_capture    = 1'b1;
               w_state_next = ST_DONE;
            end else if (bus.proc_ready) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.proc_done) begin
               w_capture    = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.done_ack) begin
               w_ack = 1'b1;
               if (BACK_TO_BACK && w_token_avail) begin
                  w_pop        = 1'b1;
                  w_state_next = ST_START;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   kernel_cc_sat_counter #(.WIDTH(CNT_WIDTH)) u_task_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (bus.cnt_clear),
      .i_load1 (1'b0),
      .i_inc   (w_ack),
      .o_count (w_task_cnt)
   );

   // The in-flight latency counter is deliberately immune to cnt_clear.
   kernel_cc_sat_counter #(.WIDTH(CNT_WIDTH)) u_lat_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (1'b0),
      .i_load1 (w_pop),
      .i_inc   (is_in_flight(r_state)),
      .o_count (w_lat_cnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_lat <= '0;
      end else if (bus.cnt_clear) begin
         r_last_lat <= '0;
      end else if (w_capture) begin
         r_last_lat <= w_lat_cnt;
      end
   end

   assign bus.start_read    = w_pop;
   assign bus.proc_start    = (r_state == ST_START);
   assign bus.done_out      = (r_state == ST_DONE);
   assign bus.proc_continue = (r_state == ST_DONE) & bus.done_ack;
   assign bus.busy          = (r_state != ST_IDLE);
   assign bus.task_cnt      = w_task_cnt;
   assign bus.last_lat      = r_last_lat;

endmodule

// File: tb/tb_kernel_cc_write_back_start_ctrl.sv
// Directed bench: a 16-bit back-to-back controller fed by a token-count FIFO model,
// plus a 3-bit pass-through-IDLE controller to reach the saturation corners quickly.
module tb_kernel_cc_write_back_start_ctrl;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   kernel_cc_write_back_start_ctrl_if #(.CNT_WIDTH(16)) bus  ();
   kernel_cc_write_back_start_ctrl_if #(.CNT_WIDTH(3))  sbus ();

   kernel_cc_write_back_start_ctrl #(.CNT_WIDTH(16), .BACK_TO_BACK(1'b1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   kernel_cc_write_back_start_ctrl #(.CNT_WIDTH(3), .BACK_TO_BACK(1'b0)) dut_s (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (sbus)
   );

   int pushed       = 0;
   int popped       = 0;
   int tests_run    = 0;
   int tests_failed = 0;
   int ps_cycles    = 0;
   int s_exp        = 0;

   // FIFO model: tokens pushed by the stimulus minus tokens popped by the DUT.
   assign bus.start_empty_n = (pushed > popped);

   always @(posedge clk) begin
      if (bus.start_read) popped <= popped + 1;
   end

   always @(posedge clk) begin
      if (bus.start_read) assert (bus.start_dout == 1'b1) else $error("protocol: pop with start_dout low");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0h", tag, got);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n            = 1'b0;
      bus.enable         = 1'b0;
      bus.start_dout     = 1'b1;
      bus.proc_ready     = 1'b0;
      bus.proc_done      = 1'b0;
      bus.done_ack       = 1'b0;
      bus.cnt_clear      = 1'b0;
      sbus.enable        = 1'b0;
      sbus.start_empty_n = 1'b1;
      sbus.start_dout    = 1'b1;
      sbus.proc_ready    = 1'b0;
      sbus.proc_done     = 1'b0;
      sbus.done_ack      = 1'b0;
      sbus.cnt_clear     = 1'b0;

      // Reset: outputs idle, waiting token must not be popped.
      repeat (2) @(negedge clk);
      bus.enable = 1'b1;
      pushed     = 1;
      #1;
      check_eq("rst_start_read", bus.start_read, 0);
      check_eq("rst_proc_start", bus.proc_start, 0);
      check_eq("rst_done_out", bus.done_out, 0);
      check_eq("rst_proc_continue", bus.proc_continue, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_task_cnt", bus.task_cnt, 0);
      check_eq("rst_last_lat", bus.last_lat, 0);
      @(negedge clk); #1;
      check_eq("rst_no_pop", popped, 0);

      // Single task: ready at +2, done at +5, ack at +6.
      reset_n = 1'b1;
      #1;
      check_eq("t1_pop", bus.start_read, 1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.proc_ready = (k == 2);
         bus.proc_done  = (k == 5);
         bus.done_ack   = (k == 6);
         #1;
         ps_cycles += int'(bus.proc_start);
         if (k == 1) check_eq("t1_no_second_pop", bus.start_read, 0);
         if (k == 6) begin
            check_eq("t1_done_out", bus.done_out, 1);
            check_eq("t1_proc_continue", bus.proc_continue, 1);
            check_eq("t1_last_lat", bus.last_lat, 6);
         end
      end
      check_eq("t1_proc_start_cycles", ps_cycles, 3);
      check_eq("t1_task_cnt", bus.task_cnt, 1);
      check_eq("t1_idle", bus.busy, 0);
      check_eq("t1_popped", popped, 1);

      // ready+done in the first START cycle goes straight to DONE.
      @(negedge clk);
      pushed = 2;
      #1;
      check_eq("t2_pop", bus.start_read, 1);
      @(negedge clk);
      bus.proc_ready = 1'b1;
      bus.proc_done  = 1'b1;
      #1;
      check_eq("t2_proc_start", bus.proc_start, 1);
      @(negedge clk);
      bus.proc_ready = 1'b0;
      bus.proc_done  = 1'b0;
      bus.done_ack   = 1'b1;
      #1;
      check_eq("t2_direct_done", bus.done_out, 1);
      check_eq("t2_last_lat", bus.last_lat, 1);
      check_eq("t2_no_pop_empty", bus.start_read, 0);
      @(negedge clk);
      bus.done_ack = 1'b0;
      #1;
      check_eq("t2_task_cnt", bus.task_cnt, 2);
      check_eq("t2_idle", bus.busy, 0);

      // Clear, then three back-to-back tasks from a 3-token FIFO.
      @(negedge clk);
      bus.cnt_clear = 1'b1;
      @(negedge clk);
      bus.cnt_clear = 1'b0;
      #1;
      check_eq("t3_clr_task_cnt", bus.task_cnt, 0);
      check_eq("t3_clr_last_lat", bus.last_lat, 0);
      pushed = 5;
      #1;
      check_eq("t3_pop0", bus.start_read, 1);
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         bus.done_ack   = 1'b0;
         bus.proc_ready = 1'b1;
         bus.proc_done  = 1'b1;
         #1;
         check_eq($sformatf("t3_start%0d", t), bus.proc_start, 1);
         @(negedge clk);
         bus.proc_ready = 1'b0;
         bus.proc_done  = 1'b0;
         bus.done_ack   = 1'b1;
         #1;
         check_eq($sformatf("t3_b2b_pop%0d", t), bus.start_read, (t < 2) ? 1 : 0);
      end
      @(negedge clk);
      bus.done_ack = 1'b0;
      #1;
      check_eq("t3_task_cnt", bus.task_cnt, 3);
      check_eq("t3_popped", popped, 5);
      check_eq("t3_idle", bus.busy, 0);

      // enable dropped in RUN: task finishes, no further pops until re-enabled.
      @(negedge clk);
      pushed = 8;
      #1;
      check_eq("t4_pop", bus.start_read, 1);
      @(negedge clk);
      bus.proc_ready = 1'b1;
      @(negedge clk);
      bus.proc_ready = 1'b0;
      bus.enable     = 1'b0;
      #1;
      check_eq("t4_run_proc_start", bus.proc_start, 0);
      check_eq("t4_run_busy", bus.busy, 1);
      @(negedge clk);
      bus.proc_done = 1'b1;
      @(negedge clk);
      bus.proc_done = 1'b0;
      bus.done_ack  = 1'b1;
      #1;
      check_eq("t4_done_out", bus.done_out, 1);
      check_eq("t4_no_pop_disabled", bus.start_read, 0);
      check_eq("t4_last_lat", bus.last_lat, 3);
      @(negedge clk);
      bus.done_ack = 1'b0;
      #1;
      check_eq("t4_idle", bus.busy, 0);
      check_eq("t4_task_cnt", bus.task_cnt, 4);
      @(negedge clk); #1;
      check_eq("t4_still_no_pop", bus.start_read, 0);
      check_eq("t4_popped", popped, 6);
      @(negedge clk);
      bus.enable = 1'b1;
      #1;
      check_eq("t4_pop_reenabled", bus.start_read, 1);
      @(negedge clk);
      bus.proc_ready = 1'b1;
      bus.proc_done  = 1'b1;
      @(negedge clk);
      bus.proc_ready = 1'b0;
      bus.proc_done  = 1'b0;
      bus.enable     = 1'b0;
      bus.done_ack   = 1'b1;
      @(negedge clk);
      bus.done_ack = 1'b0;
      #1;
      check_eq("t4_task_cnt2", bus.task_cnt, 5);

      // Async reset in RUN: outputs drop at once, queued token stays queued.
      @(negedge clk);
      pushed     = 9;
      bus.enable = 1'b1;
      #1;
      check_eq("t6_pop", bus.start_read, 1);
      @(negedge clk);
      bus.proc_ready = 1'b1;
      @(negedge clk);
      bus.proc_ready = 1'b0;
      #1;
      check_eq("t6_run_busy", bus.busy, 1);
      #1;
      reset_n = 1'b0;
      #1;
      check_eq("t6_rst_busy", bus.busy, 0);
      check_eq("t6_rst_proc_start", bus.proc_start, 0);
      check_eq("t6_rst_done_out", bus.done_out, 0);
      check_eq("t6_rst_start_read", bus.start_read, 0);
      check_eq("t6_rst_task_cnt", bus.task_cnt, 0);
      @(negedge clk); #1;
      check_eq("t6_rst_popped", popped, 8);
      reset_n = 1'b1;
      #1;
      check_eq("t6_pop_after_rst", bus.start_read, 1);
      @(negedge clk);
      bus.proc_ready = 1'b1;
      #1;
      check_eq("t6_last_lat_zero", bus.last_lat, 0);
      @(negedge clk);
      bus.proc_ready = 1'b0;
      bus.proc_done  = 1'b1;
      @(negedge clk);
      bus.proc_done = 1'b0;
      bus.enable    = 1'b0;
      bus.done_ack  = 1'b1;
      #1;
      check_eq("t6_last_lat", bus.last_lat, 2);
      @(negedge clk);
      bus.done_ack = 1'b0;
      #1;
      check_eq("t6_task_cnt", bus.task_cnt, 1);

      // 3-bit instance: latency and task count saturate at 7; clear beats ack.
      @(negedge clk);
      sbus.enable = 1'b1;
      #1;
      check_eq("s_pop", sbus.start_read, 1);
      repeat (9) @(negedge clk);
      sbus.proc_ready = 1'b1;
      sbus.proc_done  = 1'b1;
      @(negedge clk);
      sbus.proc_ready = 1'b0;
      sbus.proc_done  = 1'b0;
      sbus.done_ack   = 1'b1;
      #1;
      check_eq("s_lat_sat", sbus.last_lat, 7);
      check_eq("s_no_b2b_pop", sbus.start_read, 0);
      s_exp = 1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         sbus.done_ack = 1'b0;
         #1;
         check_eq($sformatf("s_task_cnt%0d", i), sbus.task_cnt, s_exp);
         @(negedge clk);
         sbus.proc_ready = 1'b1;
         sbus.proc_done  = 1'b1;
         @(negedge clk);
         sbus.proc_ready = 1'b0;
         sbus.proc_done  = 1'b0;
         sbus.done_ack   = 1'b1;
         s_exp = (s_exp == 7) ? 7 : s_exp + 1;
      end
      @(negedge clk);
      sbus.done_ack = 1'b0;
      #1;
      check_eq("s_task_cnt_sat", sbus.task_cnt, s_exp);
      @(negedge clk);
      sbus.proc_ready = 1'b1;
      sbus.proc_done  = 1'b1;
      @(negedge clk);
      sbus.proc_ready = 1'b0;
      sbus.proc_done  = 1'b0;
      sbus.done_ack   = 1'b1;
      sbus.cnt_clear  = 1'b1;
      @(negedge clk);
      sbus.done_ack  = 1'b0;
      sbus.cnt_clear = 1'b0;
      sbus.enable    = 1'b0;
      #1;
      check_eq("s_clear_vs_ack", sbus.task_cnt, 0);
      check_eq("s_clear_last_lat", sbus.last_lat, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
